ascon_xor_absorb: RTL

- Registered, parametrised XOR/absorb stage between the state register and the permutation.
- Successor to the combinational begin-XOR. Adds:
  - rate selection (ASCON-128 / ASCON-128a);
  - end-of-permutation key XOR (finalization);
  - byte-granular padding of partial blocks;
  - domain separation;
  - a valid/ready handshake with a one-entry output register;
  - an absorbed-block counter.
- Sits between the FSM-driven state mux and the permutation input.

---
 rtl/ascon_pack.sv | 23 ++
 rtl/ascon_pad.sv | 33 +++
 rtl/ascon_xor_absorb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon absorb/XOR datapath.
package ascon_pack;

    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;

    typedef enum logic [1:0] {
        PASS      = 2'b00,
        KEY_BEGIN = 2'b01,
        DATA      = 2'b10,
        KEY_END   = 2'b11
    } type_xor_mode;

    localparam logic [7:0]  PAD_BYTE = 8'h80;
    localparam int unsigned RATE_64  = 64;
    localparam int unsigned RATE_128 = 128;

endpackage

// File: rtl/ascon_pad.sv
// Byte-granular padding of a rate block: data bytes, then 0x80, then zeros.
module ascon_pad
    import ascon_pack::*;
#(
    parameter int unsigned RATE_BITS = 64
) (
    input  logic [RATE_BITS-1:0]         data_i,
    input  logic [$clog2(RATE_BITS/8):0] data_bytes_i,
    output logic [RATE_BITS-1:0]         pad_o,
    output logic [RATE_BITS/8-1:0]       byte_mask_o
);

    localparam int unsigned NBYTES = RATE_BITS / 8;
    localparam int unsigned NB_W   = $clog2(NBYTES) + 1;

    logic [NB_W-1:0] n_clamp;

    // Byte i sits at the MSB end; mask bit NBYTES-1-i follows the same ordering.
    always_comb begin
        n_clamp     = (data_bytes_i > NB_W'(NBYTES)) ? NB_W'(NBYTES) : data_bytes_i;
        pad_o       = '0;
        byte_mask_o = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (NB_W'(i) < n_clamp) begin
                pad_o[RATE_BITS-1-8*i -: 8] = data_i[RATE_BITS-1-8*i -: 8];
                byte_mask_o[NBYTES-1-i]     = 1'b1;
            end else if (NB_W'(i) == n_clamp) begin
                pad_o[RATE_BITS-1-8*i -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/ascon_xor_absorb.sv
// Registered XOR/absorb stage feeding the Ascon permutation, with a one-entry output register.
module ascon_xor_absorb
    import ascon_pack::*;
#(
    parameter int unsigned RATE_BITS = 64,
    parameter int unsigned KEY_BITS  = 128,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [1:0]                   mode_i,
    input  logic                         dsep_i,
    input  type_state                    state_i,
    input  logic [KEY_BITS-1:0]          key_i,
    input  logic [RATE_BITS-1:0]         data_i,
    input  logic [$clog2(RATE_BITS/8):0] data_bytes_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output type_state                    state_o,
    output logic [RATE_BITS-1:0]         cipher_o,
    output logic [CNT_W-1:0]             block_cnt_o
);

    localparam int unsigned NBYTES = RATE_BITS / 8;

    if (RATE_BITS != RATE_64 && RATE_BITS != RATE_128) begin : g_rate_chk
        $error("ascon_xor_absorb: RATE_BITS must be 64 or 128");
    end
    if (KEY_BITS != 128) begin : g_key_chk
        $error("ascon_xor_absorb: KEY_BITS must be 128");
    end

    type_xor_mode           mode;
    logic                   accept;
    logic [RATE_BITS-1:0]   pad_block;
    logic [NBYTES-1:0]      byte_mask;
    logic [RATE_BITS-1:0]   bit_mask;
    logic [319:0]           state_flat;
    logic [RATE_BITS-1:0]   rate_x;

    type_state              state_d, state_q;
    logic [RATE_BITS-1:0]   cipher_d, cipher_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic                   valid_q;

    ascon_pad #(.RATE_BITS(RATE_BITS)) u_pad (
        .data_i       (data_i),
        .data_bytes_i (data_bytes_i),
        .pad_o        (pad_block),
        .byte_mask_o  (byte_mask)
    );

    assign mode       = type_xor_mode'(mode_i);
    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign state_flat = state_i;
    assign rate_x     = state_flat[319 -: RATE_BITS] ^ pad_block;

    always_comb begin
        bit_mask = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
    end

    always_comb begin
        state_d  = state_i;
        cipher_d = rate_x & bit_mask;
        case (mode)
            KEY_BEGIN: begin
                state_d.x3 = state_i.x3 ^ key_i[127:64];
                state_d.x4 = state_i.x4 ^ key_i[63:0];
            end
            KEY_END: begin
                if (RATE_BITS == RATE_64) begin
                    state_d.x1 = state_i.x1 ^ key_i[127:64];
                    state_d.x2 = state_i.x2 ^ key_i[63:0];
                end else begin
                    state_d.x2 = state_i.x2 ^ key_i[127:64];
                    state_d.x3 = state_i.x3 ^ key_i[63:0];
                end
            end
            DATA:    state_d = type_state'({rate_x, state_flat[319-RATE_BITS:0]});
            default: ;
        endcase
        // Domain separation lands after the mode XOR so it composes with every mode.
        state_d.x4[0] = state_d.x4[0] ^ dsep_i;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            if (mode == KEY_BEGIN) begin
                cnt_d = '0;
            end else if (mode == DATA && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q  <= 1'b0;
            state_q  <= '0;
            cipher_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                state_q <= state_d;
                if (mode == DATA) begin
                    cipher_q <= cipher_d;
                end
            end else if (out_ready_i) begin
                valid_q <= 1'b0;
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid_o = valid_q;
    assign state_o     = state_q;
    assign cipher_o    = cipher_q;
    assign block_cnt_o = cnt_q;

endmodule
